// File: rtl/fifo_reader_pkg.sv
// Shared constants and helpers for the FIFO-to-stream reader.
package fifo_reader_pkg;

  localparam int BUF_DEPTH   = 2;
  localparam int OCC_WIDTH   = $clog2(BUF_DEPTH + 1);
  localparam int COUNT_WIDTH = 16;

  typedef logic [OCC_WIDTH-1:0] occ_t;

  // True when the words already committed (buffered plus in flight, minus the
  // one leaving this cycle) leave room for one more pop.
  function automatic logic room_for_pop(input occ_t occ, input logic inflight,
                                        input logic fire);
    logic [OCC_WIDTH:0] committed;
    committed = {1'b0, occ}
              + {{OCC_WIDTH{1'b0}}, inflight}
              - {{OCC_WIDTH{1'b0}}, fire};
    return committed < (OCC_WIDTH + 1)'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer: head register drives the stream directly, tail
// register absorbs the word that arrives while the head is stalled.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  occ_t                  occ_r;
  logic                  pop_s;

  // A pop on an empty buffer is ignored.
  assign pop_s     = pop && (occ_r != occ_t'(0));
  assign occ       = occ_r;
  assign head_data = head_r;

  // Buffer update: push fills the first free slot, pop shifts tail to head,
  // simultaneous push and pop keeps occupancy and order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r  <= occ_t'(0);
      head_r <= {DATA_WIDTH{1'b0}};
      tail_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case ({push, pop_s})
        2'b10: begin
          if (occ_r == occ_t'(0)) begin
            head_r <= push_data;
          end else begin
            tail_r <= push_data;
          end
          occ_r <= occ_r + occ_t'(1);
        end
        2'b01: begin
          head_r <= tail_r;
          occ_r  <= occ_r - occ_t'(1);
        end
        2'b11: begin
          if (occ_r == occ_t'(1)) begin
            head_r <= push_data;
          end else begin
            head_r <= tail_r;
            tail_r <= push_data;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream.
// Optional feature macro: FIFO_READER_COUNT_EN adds the 16-bit beat_count
// output counting delivered words (wrapping).
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_r_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
`ifdef FIFO_READER_COUNT_EN
  output logic [COUNT_WIDTH-1:0] beat_count,
`endif
  output logic                   idle
);

  logic inflight_r;
  occ_t occ_s;
  logic fire_s;

  assign m_valid = (occ_s != occ_t'(0));
  assign fire_s  = m_valid && m_ready;
  assign idle    = (occ_s == occ_t'(0)) && !inflight_r;

  // Pop only when the word it produces is guaranteed a buffer slot; the
  // m_ready term lets the pipeline sustain one word per cycle.
  assign fifo_r_en = rst_n && !fifo_empty && room_for_pop(occ_s, inflight_r, fire_s);

  // In-flight flag: set by an accepted pop, cleared when its data is captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= fifo_r_en && !fifo_empty;
    end
  end

  fifo_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_r),
    .push_data(fifo_data),
    .pop      (fire_s),
    .occ      (occ_s),
    .head_data(m_data)
  );

`ifdef FIFO_READER_COUNT_EN
  logic [COUNT_WIDTH-1:0] beat_count_r;

  // Delivered-word counter, wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_count_r <= {COUNT_WIDTH{1'b0}};
    end else if (fire_s) begin
      beat_count_r <= beat_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      beat_count_r <= beat_count_r;
    end
  end

  assign beat_count = beat_count_r;
`endif

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 DATA_WIDTH, 8, width of FIFO words and stream data, legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 fifo_empty  input  1  FIFO empty flag, pop side.
REQ-005 fifo_data  input  DATA_WIDTH  FIFO registered read data, valid one cycle after an accepted pop.
REQ-006 fifo_r_en  output  1  FIFO pop request.
REQ-007 m_valid  output  1  stream word available.
REQ-008 m_ready  input  1  downstream accepts word.
REQ-009 m_data  output  DATA_WIDTH  stream word, head of output buffer.
REQ-010 idle  output  1  high when output buffer empty and no pop in flight.
REQ-011 beat_count  output  16  delivered-word counter, present only under FIFO_READER_COUNT_EN.

Function
REQ-012 The block SHALL drain the FIFO into a valid/ready stream, preserving word order with no loss or duplication.
REQ-013 Pop accepted = fifo_r_en && !fifo_empty; fifo_r_en SHALL never be high while fifo_empty is high.
REQ-014 An accepted pop SHALL set an in-flight flag; fifo_data SHALL be captured into the output buffer on the next rising edge and the flag cleared.
REQ-015 Output buffer SHALL hold 2 entries; occupancy occ in 0..2.
REQ-016 fifo_r_en SHALL be high iff !fifo_empty && (occ + inflight - (m_valid && m_ready)) < 2; combinational m_ready-to-fifo_r_en path permitted.
REQ-017 Sustained throughput SHALL be one word per cycle when FIFO non-empty and m_ready held high.
REQ-018 m_valid SHALL equal (occ != 0); m_data SHALL be the oldest buffered word, registered, not fifo_data passed through.
REQ-019 Once m_valid is high, m_valid and m_data SHALL stay stable until m_valid && m_ready.
REQ-020 Same-cycle capture and pop SHALL leave occ unchanged with buffer order preserved; capture into an empty buffer SHALL raise m_valid the next cycle (pop-to-m_valid latency 2 cycles).
REQ-021 Buffer overflow (capture at occ=2 without pop) SHALL be impossible by REQ-016; m_valid && m_ready at occ=0 SHALL be a no-op.
REQ-022 idle SHALL equal (occ == 0) && !inflight.

Reset
REQ-023 While rst_n low at a rising edge: occ=0, inflight=0, m_valid=0, m_data=0, beat_count=0.
REQ-024 fifo_r_en SHALL be forced low combinationally while rst_n is low.
REQ-025 Reset mid-operation SHALL discard buffered and in-flight words; the in-flight word is lost, not replayed.
REQ-026 First pop SHALL be allowed the first cycle rst_n is high.

Configuration
REQ-027 Macro FIFO_READER_COUNT_EN defined: beat_count port exists, increments by 1 on each m_valid && m_ready, wraps 16'hFFFF to 16'h0000.
REQ-028 Macro undefined: beat_count port and counter logic absent; all other behaviour identical.

Structure
REQ-029 Package fifo_reader_pkg SHALL hold BUF_DEPTH=2, occupancy width constant, COUNT_WIDTH=16.
REQ-030 The 2-entry output buffer SHALL be sub-module fifo_reader_skid (push, pop, occ, head data); pop-control and counter live in the top.

Verification
REQ-031 Reset: rst_n low 3 cycles, fifo_empty=0 -> fifo_r_en=0, m_valid=0, m_data=0, idle=1 throughout.
REQ-032 Streaming: FIFO holds 8'h01..8'h08, m_ready=1 -> m_data 01..08 on 8 consecutive cycles, first at 2 cycles after first pop; beat_count=8.
REQ-033 Backpressure: 4 words A0..A3 queued, m_ready=0 10 cycles -> exactly 2 pops, occ=2, m_data=A0 stable; release m_ready -> A0..A3 in order, no gaps after first.
REQ-034 Empty guard: fifo_empty=1 toggled randomly, m_ready=1 -> fifo_r_en never high with fifo_empty, no duplicated word.
REQ-035 Reset mid-flight: pop of 8'h55 accepted, rst_n low next cycle -> 8'h55 never appears, m_valid=0, idle=1.
REQ-036 Counter wrap (FIFO_READER_COUNT_EN): 65537 beats -> beat_count=1.
